// File: rtl/serial_link_flit_serdes.sv
// rtl/serial_link_flit_serdes.sv - flit-to-beat serializer (TX) and beat-to-flit deserializer (RX)
module serial_link_flit_serdes #(
  parameter int unsigned PayloadW = 64,
  parameter int unsigned BeatW    = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  // TX: link layer -> PHY
  input  logic [PayloadW-1:0] flit_i,
  input  logic                flit_valid_i,
  output logic                flit_ready_o,
  output logic [BeatW-1:0]    beat_o,
  output logic                beat_valid_o,
  input  logic                beat_ready_i,
  // RX: PHY -> link layer
  input  logic [BeatW-1:0]    beat_i,
  input  logic                beat_valid_i,
  output logic                beat_ready_o,
  output logic [PayloadW-1:0] flit_o,
  output logic                flit_valid_o,
  input  logic                flit_ready_i,
  input  logic                rx_resync_i
);

  localparam int unsigned NumBeats = (PayloadW + BeatW - 1) / BeatW;
  localparam int unsigned CntW     = (NumBeats > 1) ? $clog2(NumBeats) : 1;
  localparam int unsigned PadW     = NumBeats * BeatW;
  localparam logic [CntW-1:0] LastCnt = CntW'(NumBeats - 1);

  // ---------------- TX path ----------------
  typedef enum logic {TX_IDLE, TX_SEND} tx_state_e;

  tx_state_e                      tx_state;
  logic [CntW-1:0]                tx_cnt;
  logic [NumBeats-1:0][BeatW-1:0] tx_buf;
  logic [PadW-1:0]                tx_pad;
  logic                           tx_last;
  logic                           tx_beat_fire;
  logic                           tx_flit_fire;

  assign tx_pad       = PadW'(flit_i);
  assign tx_last      = (tx_cnt == LastCnt);
  assign tx_beat_fire = beat_valid_o && beat_ready_i;
  // A new flit may be taken while the last beat of the current one leaves, so the link never idles.
  assign flit_ready_o = (tx_state == TX_IDLE) || (tx_last && tx_beat_fire);
  assign tx_flit_fire = flit_valid_i && flit_ready_o;
  // Beat 0 carries the least significant bits; the buffer is cleared on reset so beat_o reads 0.
  assign beat_o       = tx_buf[tx_cnt];

  // TX FSM: load a padded flit, then step through its beats as the PHY accepts them.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_state     <= TX_IDLE;
      tx_cnt       <= '0;
      tx_buf       <= '0;
      beat_valid_o <= 1'b0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (tx_flit_fire) begin
            tx_buf       <= tx_pad;
            tx_cnt       <= '0;
            tx_state     <= TX_SEND;
            beat_valid_o <= 1'b1;
          end
        end
        TX_SEND: begin
          if (tx_beat_fire) begin
            if (!tx_last) begin
              tx_cnt <= tx_cnt + 1'b1;
            end else begin
              tx_cnt <= '0;
              if (tx_flit_fire) begin
                tx_buf <= tx_pad;
              end else begin
                tx_state     <= TX_IDLE;
                beat_valid_o <= 1'b0;
              end
            end
          end
        end
        default: begin
          tx_state     <= TX_IDLE;
          beat_valid_o <= 1'b0;
        end
      endcase
    end
  end

  // ---------------- RX path ----------------
  logic [CntW-1:0]                rx_cnt;
  logic [NumBeats-1:0][BeatW-1:0] rx_buf;
  logic [NumBeats-1:0][BeatW-1:0] rx_full;
  logic                           rx_last;
  logic                           rx_fire;

  assign rx_last = (rx_cnt == LastCnt);
  // Only the completing beat must wait for a stalled output; earlier beats keep filling the buffer.
  assign beat_ready_o = !rx_resync_i && !(rx_last && flit_valid_o && !flit_ready_i);
  assign rx_fire      = beat_valid_i && beat_ready_o;

  // The completed flit is the stored beats with the arriving beat in the top slot.
  always_comb begin
    rx_full          = rx_buf;
    rx_full[LastCnt] = beat_i;
  end

  // RX assembly and output register: collect beats, publish the flit one cycle after the last beat.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_cnt       <= '0;
      rx_buf       <= '0;
      flit_o       <= '0;
      flit_valid_o <= 1'b0;
    end else begin
      if (rx_resync_i) begin
        rx_cnt <= '0;
      end else if (rx_fire) begin
        rx_buf[rx_cnt] <= beat_i;
        rx_cnt         <= rx_last ? '0 : rx_cnt + 1'b1;
      end
      if (rx_fire && rx_last) begin
        flit_o       <= PayloadW'(rx_full);
        flit_valid_o <= 1'b1;
      end else if (flit_ready_i) begin
        flit_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_link_flit_serdes.sv
// tb/tb_serial_link_flit_serdes.sv - randomized self-checking bench for serial_link_flit_serdes
module tb_serial_link_flit_serdes;

  localparam int PW = 40;
  localparam int BW = 16;
  localparam int NB = 3;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic [PW-1:0] flit_i;
  logic          flit_valid_i;
  logic          flit_ready_o;
  logic [BW-1:0] beat_o;
  logic          beat_valid_o;
  logic          beat_ready_i;
  logic [BW-1:0] beat_i;
  logic          beat_valid_i;
  logic          beat_ready_o;
  logic [PW-1:0] flit_o;
  logic          flit_valid_o;
  logic          flit_ready_i;
  logic          rx_resync_i;

  serial_link_flit_serdes #(.PayloadW(PW), .BeatW(BW)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .flit_i       (flit_i),
    .flit_valid_i (flit_valid_i),
    .flit_ready_o (flit_ready_o),
    .beat_o       (beat_o),
    .beat_valid_o (beat_valid_o),
    .beat_ready_i (beat_ready_i),
    .beat_i       (beat_i),
    .beat_valid_i (beat_valid_i),
    .beat_ready_o (beat_ready_o),
    .flit_o       (flit_o),
    .flit_valid_o (flit_valid_o),
    .flit_ready_i (flit_ready_i),
    .rx_resync_i  (rx_resync_i)
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: expected beat stream, expected flit stream, RX assembly position.
  logic [BW-1:0] tx_q[$];
  logic [PW-1:0] rx_q[$];
  logic [BW-1:0] m_slot[NB];
  int            m_cnt = 0;
  bit            mon_en = 0;
  bit            prev_stall = 0;
  logic [BW-1:0] prev_beat;

  always begin
    logic exp_br;
    logic [63:0] acc;
    @(negedge clk);
    #2;
    if (mon_en && rst_ni) begin
      // TX side
      check_eq("beat_valid", beat_valid_o, tx_q.size() > 0);
      check_eq("flit_ready", flit_ready_o, (tx_q.size() == 0) || (tx_q.size() == 1 && beat_ready_i));
      if (prev_stall) check_eq("beat_hold", beat_o, prev_beat);
      prev_stall = beat_valid_o && !beat_ready_i;
      prev_beat  = beat_o;
      if (beat_valid_o && beat_ready_i) begin
        if (tx_q.size() > 0) check_eq("beat_data", beat_o, tx_q.pop_front());
        else check_eq("beat_extra", 1, 0);
      end
      if (flit_valid_i && flit_ready_o)
        for (int k = 0; k < NB; k++) tx_q.push_back(16'(flit_i >> (BW * k)));
      // RX side
      check_eq("flit_valid", flit_valid_o, rx_q.size() > 0);
      if (flit_valid_o && rx_q.size() > 0) check_eq("flit_data", flit_o, rx_q[0]);
      exp_br = !rx_resync_i && !(m_cnt == NB - 1 && rx_q.size() > 0 && !flit_ready_i);
      check_eq("beat_ready", beat_ready_o, exp_br);
      if (flit_valid_o && flit_ready_i && rx_q.size() > 0) void'(rx_q.pop_front());
      if (rx_resync_i) begin
        m_cnt = 0;
      end else if (beat_valid_i && exp_br) begin
        m_slot[m_cnt] = beat_i;
        if (m_cnt == NB - 1) begin
          acc = '0;
          for (int k = 0; k < NB; k++) acc = acc | (64'(m_slot[k]) << (BW * k));
          rx_q.push_back(PW'(acc));
          m_cnt = 0;
        end else begin
          m_cnt++;
        end
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic tx_push(input logic [PW-1:0] f);
    bit fired = 0;
    flit_valid_i = 1'b1;
    flit_i = f;
    for (int n = 0; n < 50 && !fired; n++) begin
      #1 fired = flit_ready_o;
      @(negedge clk);
    end
    flit_valid_i = 1'b0;
    if (!fired) check_eq("tx_push_timeout", 0, 1);
  endtask

  task automatic rx_beat(input logic [BW-1:0] b);
    bit fired = 0;
    beat_valid_i = 1'b1;
    beat_i = b;
    for (int n = 0; n < 50 && !fired; n++) begin
      #1 fired = beat_ready_o;
      @(negedge clk);
    end
    beat_valid_i = 1'b0;
    if (!fired) check_eq("rx_beat_timeout", 0, 1);
  endtask

  initial begin
    rst_ni = 1'b0;
    flit_i = '0; flit_valid_i = 0; beat_ready_i = 0;
    beat_i = '0; beat_valid_i = 0; flit_ready_i = 0; rx_resync_i = 0;
    idle(2);
    #1;
    check_eq("rst_beat_valid", beat_valid_o, 0);
    check_eq("rst_flit_valid", flit_valid_o, 0);
    check_eq("rst_flit_o", flit_o, 0);
    check_eq("rst_beat_o", beat_o, 0);
    check_eq("rst_flit_ready", flit_ready_o, 1);
    check_eq("rst_beat_ready", beat_ready_o, 1);
    @(negedge clk);
    rst_ni = 1'b1;
    mon_en = 1;

    // Known flit then a random one back-to-back with the PHY always ready.
    beat_ready_i = 1'b1;
    tx_push(40'hAB_CDEF_1234);
    tx_push({8'($urandom), 32'($urandom)});
    idle(6);

    // Reassembly of the known flit; output held to inspect it.
    flit_ready_i = 1'b0;
    rx_beat(16'h1234);
    rx_beat(16'hCDEF);
    rx_beat(16'h00AB);
    #1;
    check_eq("rx_known_valid", flit_valid_o, 1);
    check_eq("rx_known_flit", flit_o, 40'hAB_CDEF_1234);
    @(negedge clk);
    flit_ready_i = 1'b1;
    idle(1);

    // Output stalled: two more beats accepted, the completing beat waits.
    flit_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) rx_beat(16'($urandom));
    beat_valid_i = 1'b1;
    beat_i = 16'($urandom);
    for (int i = 0; i < 3; i++) begin
      #1 check_eq("stall_ready", beat_ready_o, 0);
      @(negedge clk);
    end
    flit_ready_i = 1'b1;
    #1 check_eq("unstall_ready", beat_ready_o, 1);
    @(negedge clk);
    beat_valid_i = 1'b0;
    idle(3);

    // Resync after one beat; only the following three beats form a flit.
    rx_beat(16'hDEAD);
    rx_resync_i = 1'b1;
    beat_valid_i = 1'b1;
    beat_i = 16'hBEEF;
    @(negedge clk);
    rx_resync_i = 1'b0;
    beat_valid_i = 1'b0;
    rx_beat(16'h1111);
    rx_beat(16'h2222);
    rx_beat(16'h0033);
    #1 check_eq("resync_flit", flit_o, 40'h33_2222_1111);
    idle(3);

    // Random traffic on both paths.
    for (int i = 0; i < 3000; i++) begin
      flit_valid_i = ($urandom_range(3) != 0);
      flit_i       = {8'($urandom), 32'($urandom)};
      beat_ready_i = ($urandom_range(3) != 0);
      beat_valid_i = ($urandom_range(3) != 0);
      beat_i       = 16'($urandom);
      flit_ready_i = ($urandom_range(2) != 0);
      rx_resync_i  = ($urandom_range(31) == 0);
      @(negedge clk);
    end
    flit_valid_i = 0; beat_valid_i = 0; rx_resync_i = 0;
    beat_ready_i = 1; flit_ready_i = 1;
    idle(10);

    // Reset while the TX is mid-flit (tx_cnt=1) and the RX holds a partial flit.
    rx_resync_i = 1'b1;
    @(negedge clk);
    rx_resync_i = 1'b0;
    tx_push(40'h55_6677_8899);
    beat_valid_i = 1'b1;
    beat_i = 16'hAAAA;
    @(negedge clk);
    beat_valid_i = 1'b0;
    #3 rst_ni = 1'b0;
    #1;
    check_eq("midrst_beat_valid", beat_valid_o, 0);
    check_eq("midrst_flit_ready", flit_ready_o, 1);
    check_eq("midrst_beat_ready", beat_ready_o, 1);
    check_eq("midrst_beat_o", beat_o, 0);
    tx_q.delete();
    rx_q.delete();
    m_cnt = 0;
    prev_stall = 0;
    idle(2);
    rst_ni = 1'b1;
    idle(5);
    rx_beat(16'h0101);
    rx_beat(16'h0202);
    rx_beat(16'h0003);
    #1 check_eq("post_rst_flit", flit_o, 40'h03_0202_0101);
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/serial_link_flit_serdes.md
SERIAL_LINK_FLIT_SERDES -- requirements
Module: serial_link_flit_serdes

Interface
REQ-001 SHALL have parameter PayloadW, default 64, flit payload width in bits (>=1).
REQ-002 SHALL have parameter BeatW, default 16, PHY beat width (NumLanes*2 for DDR, NumLanes for SDR).
REQ-003 SHALL derive NumBeats = ceil(PayloadW/BeatW) and counter width max(1,$clog2(NumBeats)).
REQ-004 SHALL have port clk_i, input, 1, system clock.
REQ-005 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port flit_i, input, PayloadW, TX flit from the link layer.
REQ-007 SHALL have ports flit_valid_i (input, 1) and flit_ready_o (output, 1), TX flit handshake.
REQ-008 SHALL have port beat_o, output, BeatW, TX beat to the PHY transmitter.
REQ-009 SHALL have ports beat_valid_o (output, 1) and beat_ready_i (input, 1), TX beat handshake.
REQ-010 SHALL have port beat_i, input, BeatW, RX beat from the PHY receiver.
REQ-011 SHALL have ports beat_valid_i (input, 1) and beat_ready_o (output, 1), RX beat handshake.
REQ-012 SHALL have port flit_o, output, PayloadW, reassembled RX flit.
REQ-013 SHALL have ports flit_valid_o (output, 1) and flit_ready_i (input, 1), RX flit handshake.
REQ-014 SHALL have port rx_resync_i, input, 1, discards the partial RX flit and realigns to beat 0.

Function
REQ-015 TX FSM SHALL have states IDLE and SEND; flit_ready_o=1 in IDLE.
REQ-016 On flit handshake in IDLE, SHALL latch flit_i zero-padded to NumBeats*BeatW, set tx_cnt=0, go to SEND.
REQ-017 In SEND, SHALL drive beat_valid_o=1 and beat_o = padded[tx_cnt*BeatW +: BeatW], beat 0 = LSBs.
REQ-018 beat_valid_o SHALL NOT depend combinationally on beat_ready_i; beat_o stable while valid and not ready.
REQ-019 On beat handshake with tx_cnt<NumBeats-1, SHALL increment tx_cnt.
REQ-020 flit_ready_o SHALL also be 1 in SEND when tx_cnt==NumBeats-1 and beat_ready_i=1.
REQ-021 On last-beat handshake, SHALL load a concurrent flit and stay in SEND with tx_cnt=0 (no bubble); otherwise SHALL return to IDLE.
REQ-022 RX SHALL write beat_i into assembly slot rx_cnt on each RX beat handshake.
REQ-023 RX SHALL increment rx_cnt on non-last beats, and wrap it to 0 on beat NumBeats-1.
REQ-024 On the last beat, SHALL load {beat_i, assembled beats}, truncated to PayloadW, into the flit_o register, with flit_valid_o=1 the next cycle (1-cycle latency).
REQ-025 flit_o SHALL hold stable while flit_valid_o=1 and flit_ready_i=0; flit_valid_o SHALL clear on handshake unless a new flit loads the same cycle.
REQ-026 beat_ready_o SHALL be 0 when rx_resync_i=1, or when rx_cnt==NumBeats-1 and flit_valid_o=1 and flit_ready_i=0; otherwise 1.
REQ-027 While the output is stalled, SHALL still accept beats 0..NumBeats-2 into the assembly buffer.
REQ-028 rx_resync_i SHALL set rx_cnt=0 next cycle, drop no already-completed flit, and accept no beat that cycle.
REQ-029 With NumBeats=1, SHALL pass every TX flit as one beat and produce one RX flit per beat.
REQ-030 TX and RX paths SHALL be fully independent, with no shared state.

Reset
REQ-031 On rst_ni low, SHALL set TX FSM=IDLE, tx_cnt=0, rx_cnt=0.
REQ-032 On rst_ni low, SHALL set beat_valid_o=0, flit_valid_o=0, flit_o=0, beat_o=0.
REQ-033 During and after reset, SHALL set flit_ready_o=1 and beat_ready_o=1.
REQ-034 Reset mid-flit SHALL discard the in-flight TX and RX flit; no partial beat or flit is emitted after release.

Verification (PayloadW=40, BeatW=16, NumBeats=3)
REQ-035 SHALL cover: flit 0xAB_CDEF_1234, beat_ready_i=1 -> beats 0x1234, 0xCDEF, 0x00AB on 3 consecutive cycles.
REQ-036 SHALL cover: two flits back-to-back, ready=1 -> 6 beats, no idle cycle between flits.
REQ-037 SHALL cover: beats 0x1234, 0xCDEF, 0x00AB -> flit_o=0xAB_CDEF_1234, flit_valid_o=1 one cycle after the third beat.
REQ-038 SHALL cover: flit_ready_i=0 and 6 beats offered -> beats 3-4 accepted, beat 5 stalled (beat_ready_o=0) until the first flit is taken, then second flit correct.
REQ-039 SHALL cover: rx_resync_i after 1 beat, then 3 beats -> exactly one flit, built from the post-resync beats.
REQ-040 SHALL cover: rst_ni asserted in SEND at tx_cnt=1 -> beat_valid_o=0 immediately, FSM=IDLE after release.
